// File: rtl/lz_normalizer.sv
// Normaliser for mantissas: shifts a word left by its leading-zero count so the MSB lands at N-1.
// One binary shift stage (2^i) is applied per clock, walking the count bits from MSB down to bit 0.
module lz_normalizer #(
    parameter  int N  = 32,
    localparam int S  = $clog2(N),
    localparam int CW = S + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [CW-1:0] in_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_zero,
    output logic          out_norm
);

    localparam int IW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          zero_q, zero_d;
    logic [CW-1:0] cnt_sat;
    logic [N-1:0]  stage_out [S];

    assign cnt_sat = (in_count > CW'(N)) ? CW'(N) : in_count;

    // Candidate result of every stage; the active one is picked by idx_q.
    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_stage
            assign stage_out[gi] = cnt_q[gi] ? (data_q << (2 ** gi)) : data_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        zero_d    = zero_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // A full-width count never reaches a stage: the word is cleared here.
                    cnt_d   = cnt_sat;
                    zero_d  = cnt_sat[S];
                    data_d  = cnt_sat[S] ? '0 : in_data;
                    idx_d   = IW'(S - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                data_d = stage_out[idx_q];
                idx_d  = idx_q - 1'b1;
                if (idx_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data = data_q;
    assign out_zero = zero_q;
    assign out_norm = data_q[N-1];

endmodule

// File: tb/tb_lz_normalizer.sv
// Randomised and directed bench for lz_normalizer against an arithmetic shift reference.
module tb_lz_normalizer;

    localparam int N  = 32;
    localparam int S  = 5;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data = '0;
    logic [CW-1:0] in_count = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_data;
    logic          out_zero;
    logic          out_norm;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lz_normalizer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_norm  (out_norm)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int c);
        if (c >= N) return '0;
        return d << c;
    endfunction

    function automatic int ref_lz(input logic [N-1:0] d);
        for (int b = N - 1; b >= 0; b--) begin
            if (d[b]) return N - 1 - b;
        end
        return N;
    endfunction

    // One complete transaction: accept, measure latency, hold in DONE, handshake.
    task automatic run_item(input logic [N-1:0] d, input logic [CW-1:0] c, input int hold);
        logic [N-1:0] exp_data;
        logic         exp_zero;
        int           lat;
        exp_data = ref_shift(d, int'(c));
        exp_zero = (int'(c) >= N);
        check("in_ready_idle", 64'(in_ready), 64'(1));
        in_data  = d;
        in_count = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(S));
        check("out_data", 64'(out_data), 64'(exp_data));
        check("out_zero", 64'(out_zero), 64'(exp_zero));
        check("out_norm", 64'(out_norm), 64'(exp_data[N-1]));
        // Offer a junk item while stalled; it must not be taken.
        in_valid = (hold > 0);
        in_data  = ~d;
        in_count = CW'(3);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_ready", 64'(in_ready), 64'(0));
            check("hold_data", {31'd0, out_zero, out_data}, {31'd0, exp_zero, exp_data});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", 64'(out_valid), 64'(0));
        $display("item d=0x%08h c=%0d hold=%0d -> 0x%08h zero=%0b norm=%0b lat=%0d",
                 d, c, hold, out_data, out_zero, out_norm, lat);
    endtask

    initial begin
        logic [N-1:0] w;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out", {61'd0, out_valid, out_zero, out_norm}, 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_item(32'h0000_1234, 6'd19, 0);
        run_item(32'h8000_0001, 6'd0, 0);
        run_item(32'h0000_0000, 6'd32, 0);
        run_item(32'h0000_0000, 6'd63, 0);
        run_item(32'hDEAD_BEEF, 6'd40, 1);
        run_item(32'h0000_00F0, 6'd24, 10);

        // Abort in the middle of SHIFT.
        in_data  = 32'h0001_0000;
        in_count = 6'd15;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(in_ready), 64'(1));
        check("abort_out", {61'd0, out_valid, out_zero, out_norm}, 64'(0));
        check("abort_data", 64'(out_data), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_valid", 64'(out_valid), 64'(0));
        run_item(32'h0000_0003, 6'd30, 0);

        // Correct counts: every result must be normalised.
        for (int k = 0; k < 40; k++) begin
            w = $urandom;
            w = w >> $urandom_range(0, 31);
            if (w == '0) w = 32'h1;
            run_item(w, CW'(ref_lz(w)), int'($urandom_range(0, 3)));
            check("rand_norm", 64'(out_norm), 64'(1));
        end
        // Arbitrary counts, including saturating ones.
        for (int k = 0; k < 30; k++) begin
            run_item($urandom, CW'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lz_normalizer.md
Name: lz_normalizer

Overview:
- Consumes a data word and its leading-zero count, as produced by the team's leading-zero counter, and left-shifts the word so its MSB is set.
- This is the mantissa-normalisation step that follows leading-zero counting.
- Iterative logarithmic shifter: one binary shift stage per clock, with a valid/ready handshake on both sides.
- Sits between the LZC result register and downstream formatting logic in the I2C peripheral datapath.

Parameters:
- N, 32: data width. Must be a power of two, N >= 4.
- S, $clog2(N): number of shift stages. Derived; do not override.
- CW, S+1: count width, which can represent 0..N.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word and count are valid.
- in_ready  output  1  block can accept an input.
- in_data  input  N  word to normalise.
- in_count  input  CW  leading-zero count of in_data (0..N).
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  N  in_data shifted left by the saturated count, zero-filled.
- out_zero  output  1  saturated count == N; out_data is 0.
- out_norm  output  1  out_data[N-1].

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, out_data=0, out_zero=0, out_norm=0, internal count register 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: capture in_data and cnt=min(in_count,N); set stage index i=S-1; go to SHIFT.
  - in_count > N saturates to N.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each edge: if cnt[i]==1, data <= data << 2^i, else unchanged; then i decrements.
  - After the edge that processes i=0, go to DONE.
  - Exactly S cycles in SHIFT.
- cnt == N: bit S of the count is handled in the capture edge by loading data=0. No stage ever shifts by N.
- DONE:
  - out_valid=1; out_data, out_zero and out_norm are stable while out_valid=1 and out_ready=0.
  - On out_ready at an edge: out_valid<=0, go to IDLE.
  - in_ready stays 0 in DONE; no same-cycle re-accept.
- Latency: input accepted at edge k gives out_valid=1 after edge k+S (5 cycles for N=32). Minimum throughput is one result per S+2 cycles.
- out_zero is valid with out_valid and equals (saturated cnt == N). out_zero is independent of data content.
- A count smaller than the true leading-zero count gives out_norm=0. A larger count discards MSBs. Neither case is flagged as an error; both are caller responsibility.
- in_valid while in_ready=0 is ignored; the source must hold it.
- Reset mid-SHIFT or mid-DONE aborts immediately: no out_valid is produced for the aborted item.
- out_data holds its last value in IDLE. Consumers use it only with out_valid.

Test Plan:
- in_data=0x0000_1234, in_count=19 -> out_valid exactly 5 cycles after accept, out_data=0x91A0_0000, out_norm=1, out_zero=0.
- in_data=0x8000_0001, in_count=0 -> out_data=0x8000_0001, out_norm=1, latency 5.
- in_data=0, in_count=32 -> out_data=0, out_zero=1, out_norm=0. Repeat with in_count=63: saturated, same result.
- Backpressure: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0 throughout. New in_valid is ignored until after the handshake; the next item completes correctly.
- Assert rst_n low during SHIFT (in_data=0x0001_0000, count 15) -> outputs return to reset values immediately. After release, a fresh item 0x0000_0003, count 30 -> 0xC000_0000.
- Random sweep: random nonzero words with the correct count (driven through the existing leading-zero counter) -> out_norm=1 always, and out_data matches the reference shift.
